stable_matching_checker: RTL and testbench

//  Sequential verifier for a stable-matching result. Reads the packed preference vector and the per-R match list

---
 rtl/stable_matching_pkg.sv | 34 +++
 rtl/stable_matching_rank.sv | 33 +++
 rtl/stable_matching_checker.sv | 220 ++++++++++++++++++++++
 tb/tb_stable_matching_checker.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/stable_matching_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stable_matching_pkg
// Brief    : Shared widths, FSM encoding and preference-vector offsets.
// Revision : 1.0
// ============================================================================
package stable_matching_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INVERT = 2'd1,
        ST_SCAN   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Index width for a range of n values; never narrower than one bit.
    function automatic int log2w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    function automatic int rpref_off(input int i, input int j, input int logs, input int kr);
        return logs * kr * i + logs * j;
    endfunction

    function automatic int spref_off(input int i, input int j, input int logr, input int ks,
                                     input int rbase);
        return rbase + logr * ks * i + logr * j;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stable_matching_rank.sv
`default_nettype none
// ============================================================================
// Module   : stable_matching_rank
// Brief    : Position of key in one responder's list; Kr when key is absent.
// Revision : 1.0
// ============================================================================
module stable_matching_rank
    import stable_matching_pkg::*;
#(
    parameter int Kr   = 10,
    parameter int LOGS = 4,
    localparam int RW  = log2w(Kr + 1)
)(
    input  logic [LOGS-1:0] list [Kr],
    input  logic [LOGS-1:0] key,
    output logic            found,
    output logic [RW-1:0]   rank
);

    // Scan from the tail so the lowest matching index is the one left standing.
    always_comb begin
        found = 1'b0;
        rank  = RW'(Kr);
        for (int j = Kr - 1; j >= 0; j--) begin
            if (list[j] == key) begin
                found = 1'b1;
                rank  = RW'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stable_matching_checker.sv
`default_nettype none
// ============================================================================
// Module   : stable_matching_checker
// Brief    : Sequential stability check of a matching; reports blocking pair
//            or malformed matching. STABLE_MATCHING_CHECKER_COUNT_EN enables a
//            full scan with a blocking-pair counter.
// Revision : 1.0
// ============================================================================
module stable_matching_checker
    import stable_matching_pkg::*;
#(
    parameter int Kr = 10,
    parameter int Ks = 10,
    parameter int S  = 10,
    parameter int R  = 10,
    localparam int LOGS = log2w(S),
    localparam int LOGR = log2w(R)
`ifdef STABLE_MATCHING_CHECKER_COUNT_EN
   ,localparam int BCW  = log2w(S * Ks + 1)
`endif
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [R*Kr*LOGS+S*Ks*LOGR-1:0]   g,
    input  logic [R*LOGS-1:0]                match_list,
    input  logic [R-1:0]                     match_valid,
    output logic                             busy,
    output logic                             done,
    output logic                             stable,
    output logic                             error,
    output logic [LOGS-1:0]                  block_s,
    output logic [LOGR-1:0]                  block_r
`ifdef STABLE_MATCHING_CHECKER_COUNT_EN
   ,output logic [BCW-1:0]                   blocking_count
`endif
);

    localparam int LOGKS = log2w(Ks);
    localparam int RW    = log2w(Kr + 1);
    localparam int CWR   = LOGR + 1;
    localparam int CWS   = LOGS + 1;
    localparam int CWK   = LOGKS + 1;

    state_t             r_state, w_next;
    logic [CWR-1:0]     r_ridx;
    logic [CWS-1:0]     r_sidx;
    logic [CWK-1:0]     r_kidx;
    logic [LOGR-1:0]    r_partner [S];
    logic [S-1:0]       r_pvalid;
    logic               r_found;

    logic [LOGS-1:0]    rpref [R][Kr];
    logic [LOGR-1:0]    spref [S][Ks];

    for (genvar i = 0; i < R; i++) begin : g_rpref
        for (genvar j = 0; j < Kr; j++) begin : g_ent
            assign rpref[i][j] = g[rpref_off(i, j, LOGS, Kr) +: LOGS];
        end
    end

    for (genvar i = 0; i < S; i++) begin : g_spref
        for (genvar j = 0; j < Ks; j++) begin : g_ent
            assign spref[i][j] = g[spref_off(i, j, LOGR, Ks, R * Kr * LOGS) +: LOGR];
        end
    end

    // INVERT datapath
    logic [LOGR-1:0]    w_r;
    logic [LOGS-1:0]    w_inv_s;
    logic               w_inv_err;

    assign w_r       = r_ridx[LOGR-1:0];
    assign w_inv_s   = match_list[w_r * LOGS +: LOGS];
    assign w_inv_err = match_valid[w_r] && ((32'(w_inv_s) >= S) || r_pvalid[w_inv_s]);

    // SCAN datapath
    logic [LOGS-1:0]    w_s;
    logic [LOGKS-1:0]   w_k;
    logic [LOGR-1:0]    w_rr, w_rr_safe;
    logic               w_rr_ok, w_hit, w_block, w_snext, w_slast;
    logic [LOGS-1:0]    w_mslot;
    logic [LOGS-1:0]    w_list [Kr];
    logic               w_found_s, w_found_m;
    logic [RW-1:0]      w_rank_s, w_rank_m;

    assign w_s       = r_sidx[LOGS-1:0];
    assign w_k       = r_kidx[LOGKS-1:0];
    assign w_rr      = spref[w_s][w_k];
    assign w_rr_ok   = 32'(w_rr) < R;
    assign w_rr_safe = w_rr_ok ? w_rr : '0;
    assign w_mslot   = match_list[w_rr_safe * LOGS +: LOGS];

    always_comb begin
        for (int j = 0; j < Kr; j++) w_list[j] = rpref[w_rr_safe][j];
    end

    stable_matching_rank #(.Kr(Kr), .LOGS(LOGS)) u_rank_s (
        .list  (w_list),
        .key   (w_s),
        .found (w_found_s),
        .rank  (w_rank_s)
    );

    stable_matching_rank #(.Kr(Kr), .LOGS(LOGS)) u_rank_m (
        .list  (w_list),
        .key   (w_mslot),
        .found (w_found_m),
        .rank  (w_rank_m)
    );

    // Reaching the partner means every later entry is less preferred by s.
    assign w_hit   = r_pvalid[w_s] && (w_rr == r_partner[w_s]);
    assign w_block = w_rr_ok && !w_hit && w_found_s &&
                     (!match_valid[w_rr_safe] || (w_rank_s < w_rank_m));
    assign w_snext = (w_rr_ok && w_hit) || (r_kidx == CWK'(Ks - 1));
    assign w_slast = w_snext && (r_sidx == CWS'(S - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_INVERT;
            end
            ST_INVERT: begin
                busy = 1'b1;
                if (w_inv_err)                      w_next = ST_DONE;
                else if (r_ridx == CWR'(R - 1))     w_next = ST_SCAN;
            end
            ST_SCAN: begin
                busy = 1'b1;
`ifdef STABLE_MATCHING_CHECKER_COUNT_EN
                if (w_slast)                        w_next = ST_DONE;
`else
                if (w_block || w_slast)             w_next = ST_DONE;
`endif
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ridx   <= '0;
            r_sidx   <= '0;
            r_kidx   <= '0;
            r_pvalid <= '0;
            r_found  <= 1'b0;
            stable   <= 1'b0;
            error    <= 1'b0;
            block_s  <= '0;
            block_r  <= '0;
`ifdef STABLE_MATCHING_CHECKER_COUNT_EN
            blocking_count <= '0;
`endif
            for (int i = 0; i < S; i++) r_partner[i] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ridx   <= '0;
                        r_sidx   <= '0;
                        r_kidx   <= '0;
                        r_pvalid <= '0;
                        r_found  <= 1'b0;
                        stable   <= 1'b0;
                        error    <= 1'b0;
                        block_s  <= '0;
                        block_r  <= '0;
`ifdef STABLE_MATCHING_CHECKER_COUNT_EN
                        blocking_count <= '0;
`endif
                    end
                end
                ST_INVERT: begin
                    r_ridx <= r_ridx + 1'b1;
                    if (w_inv_err) begin
                        error <= 1'b1;
                    end else if (match_valid[w_r]) begin
                        r_partner[w_inv_s] <= w_r;
                        r_pvalid[w_inv_s]  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (w_block) begin
                        r_found <= 1'b1;
                        if (!r_found) begin
                            block_s <= w_s;
                            block_r <= w_rr;
                        end
`ifdef STABLE_MATCHING_CHECKER_COUNT_EN
                        if (blocking_count != '1) blocking_count <= blocking_count + 1'b1;
`endif
                    end
                    if (w_snext) begin
                        r_sidx <= r_sidx + 1'b1;
                        r_kidx <= '0;
                    end else begin
                        r_kidx <= r_kidx + 1'b1;
                    end
                    if (w_next == ST_DONE) stable <= !(r_found || w_block);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stable_matching_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_stable_matching_checker
// Brief    : Directed scoreboard bench for stable_matching_checker, S=R=Ks=Kr=2.
// Revision : 1.0
// ============================================================================
module tb_stable_matching_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] g;
    logic [1:0] match_list;
    logic [1:0] match_valid;
    logic       busy, done, stable, error;
    logic       block_s, block_r;
`ifdef STABLE_MATCHING_CHECKER_COUNT_EN
    logic [2:0] blocking_count;
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    stable_matching_checker #(.Kr(2), .Ks(2), .S(2), .R(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .g           (g),
        .match_list  (match_list),
        .match_valid (match_valid),
        .busy        (busy),
        .done        (done),
        .stable      (stable),
        .error       (error),
        .block_s     (block_s),
        .block_r     (block_r)
`ifdef STABLE_MATCHING_CHECKER_COUNT_EN
       ,.blocking_count (blocking_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int stable;
        int error;
        int bs;
        int br;
        int cnt;
        int lat;
        int c0;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int get_cnt();
`ifdef STABLE_MATCHING_CHECKER_COUNT_EN
        return int'(blocking_count);
`else
        return 0;
`endif
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", int'(done), 0);
            end else begin
                e = sb.pop_front();
                chk("latency", cyc - e.c0 - 1, e.lat);
                chk("busy_at_done", int'(busy), 0);
                chk("stable", int'(stable), e.stable);
                chk("error", int'(error), e.error);
                chk("block_s", int'(block_s), e.bs);
                chk("block_r", int'(block_r), e.br);
                if (CNT) chk("blocking_count", get_cnt(), e.cnt);
            end
        end
    end

    task automatic run(input logic [1:0] ml, input logic [1:0] mv, input int st, input int er,
                       input int bs, input int br, input int cnt, input int lat,
                       input bit extra_start);
        exp_t e;
        bit   seen;
        @(negedge clk);
        match_list  = ml;
        match_valid = mv;
        start       = 1'b1;
        e.stable = st; e.error = er; e.bs = bs; e.br = br; e.cnt = cnt; e.lat = lat; e.c0 = cyc;
        sb.push_back(e);
        @(negedge clk);
        start = extra_start;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("stable_hold", int'(stable), st);
    endtask

    initial begin
        int ndone;
        rst         = 1'b1;
        start       = 1'b0;
        // rPref r0=[s1,s0] r1=[s0,s1] in bits 3:0; sPref s0=[r0,r1] s1=[r0,r1] in bits 7:4
        g           = 8'hA9;
        match_list  = 2'b00;
        match_valid = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_stable", int'(stable), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_block_s", int'(block_s), 0);
        chk("rst_block_r", int'(block_r), 0);
        if (CNT) chk("rst_count", get_cnt(), 0);
        rst = 1'b0;

        // stable matching r0<-s1, r1<-s0
        run(2'b01, 2'b11, 1, 0, 0, 0, 0, 5, 1'b0);
        // r0<-s0, r1<-s1: (s1,r0) blocks
        run(2'b10, 2'b11, 0, 0, 1, 0, 1, CNT ? 5 : 4, 1'b0);
        // duplicate s0: malformed, exits at end of INVERT
        run(2'b00, 2'b11, 0, 1, 0, 0, 0, 2, 1'b0);
        // only r0<-s1 valid: (s0,r1) blocks
        run(2'b01, 2'b01, 0, 0, 0, 1, 1, CNT ? 5 : 4, 1'b0);
        // start re-pulsed while busy must not disturb the check
        run(2'b10, 2'b11, 0, 0, 1, 0, 1, CNT ? 5 : 4, 1'b1);

        // reset during the last SCAN cycle of the stable case
        @(negedge clk);
        match_list  = 2'b01;
        match_valid = 2'b11;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_stable", int'(stable), 0);
        chk("abort_error", int'(error), 0);
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        run(2'b10, 2'b11, 0, 0, 1, 0, 1, CNT ? 5 : 4, 1'b0);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
        $fatal(1);
    end

endmodule
`default_nettype wire
